// File: rtl/r_channel_arbiter.sv
// Burst-granular round-robin arbiter merging several AXI R sources into one
// registered beat stream; a winning source holds the path until its RLAST beat.
module r_channel_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DW      = 42,
  localparam int unsigned SW     = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*DW-1:0] src_data,
  output logic [NUM_SRC-1:0]    src_ready,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic [SW-1:0]         out_src,
  input  logic                  out_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_lock_src;
  logic [SW-1:0] r_rr_ptr;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [SW-1:0] r_out_src;

  logic          w_load_en;
  logic          w_grant_vld;
  logic [SW-1:0] w_grant;
  logic          w_accept;
  logic [DW-1:0] w_beat;

  // (base + off) mod NUM_SRC, with off < NUM_SRC
  function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base,
                                           input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return SW'(sum);
  endfunction

  assign w_load_en = !r_out_valid || out_ready;

  // Grant: locked source during a burst, otherwise first valid from rr_ptr
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    if (r_state == ST_LOCK) begin
      w_grant_vld = 1'b1;
      w_grant     = r_lock_src;
    end else begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (!w_grant_vld && src_valid[rr_idx(r_rr_ptr, k)]) begin
          w_grant_vld = 1'b1;
          w_grant     = rr_idx(r_rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (rst_n && w_grant_vld) src_ready[w_grant] = w_load_en;
  end

  assign w_accept = w_grant_vld && src_valid[w_grant] && src_ready[w_grant];
  assign w_beat   = src_data[32'(w_grant)*DW +: DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lock_src  <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_beat;
      r_out_src   <= w_grant;
      if (w_beat[0]) begin
        r_state  <= ST_IDLE;
        r_rr_ptr <= rr_idx(w_grant, 1);
      end else begin
        r_state    <= ST_LOCK;
        r_lock_src <= w_grant;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_r_channel_arbiter.sv
// Scoreboard bench for r_channel_arbiter: per-source beat queues drive the
// inputs, expected beats are queued in hand-computed order and checked on output.
module tb_r_channel_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 42;
  localparam int unsigned SW = 2;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NS-1:0]     src_valid;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_src;
  logic              out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t          exp_q[$];
  logic [DW:0]   sq[NS][$];   // bit DW set marks a one-cycle bubble
  logic [NS-1:0] fire;
  logic [NS-1:0] shown_bubble;

  r_channel_arbiter #(.NUM_SRC(NS), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mk(input int s, input int n, input bit last);
    return {26'(n), 8'(s), 7'h2A, last};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic load(input int s, input logic [DW-1:0] d);
    sq[s].push_back({1'b0, d});
  endtask

  task automatic bubble(input int s);
    sq[s].push_back({1'b1, {DW{1'b0}}});
  endtask

  task automatic expect_beat(input int s, input logic [DW-1:0] d);
    exp_t e;
    e.src  = SW'(s);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Handshake sampled mid-cycle, queues advanced just after the edge
  initial begin
    fire         = '0;
    shown_bubble = '0;
    forever begin
      @(negedge clk);
      fire = src_valid & src_ready;
    end
  end

  initial begin
    logic [DW:0] h;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if ((fire[i] || shown_bubble[i]) && sq[i].size() > 0) void'(sq[i].pop_front());
        shown_bubble[i] = 1'b0;
        if (sq[i].size() > 0) begin
          h = sq[i][0];
          src_valid[i]           = !h[DW];
          src_data[i*DW +: DW]   = h[DW-1:0];
          shown_bubble[i]        = h[DW];
        end else begin
          src_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every beat taken downstream must match the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat actual=%h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(out_data), 64'(e.data));
          chk("beat_src", 64'(out_src), 64'(e.src));
        end
      end
    end
  end

  initial begin
    int cyc;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    src_valid = '0;
    src_data  = '0;

    // Single-beat round-robin, sources already valid during reset
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NS; s++) begin
        load(s, mk(s, r, 1'b1));
        expect_beat(s, mk(s, r, 1'b1));
      end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain(cyc);
    chk("rr_single_cycles", 64'(cyc), 64'd9);

    // Burst lock: src0 4-beat burst, then src1, then src2
    for (int n = 0; n < 4; n++) begin
      load(0, mk(0, n, n == 3));
      expect_beat(0, mk(0, n, n == 3));
    end
    load(1, mk(1, 0, 1'b1));
    load(2, mk(2, 0, 1'b1));
    expect_beat(1, mk(1, 0, 1'b1));
    expect_beat(2, mk(2, 0, 1'b1));
    wait_drain(cyc);
    chk("burst_lock_cycles", 64'(cyc), 64'd8);

    // Mid-burst gap: move rr_ptr to 2, then src2 stalls 3 cycles while src3 waits
    load(1, mk(1, 9, 1'b1));
    expect_beat(1, mk(1, 9, 1'b1));
    wait_drain(cyc);
    load(2, mk(2, 0, 1'b0));
    bubble(2);
    bubble(2);
    bubble(2);
    load(2, mk(2, 1, 1'b0));
    load(2, mk(2, 2, 1'b1));
    load(3, mk(3, 0, 1'b1));
    expect_beat(2, mk(2, 0, 1'b0));
    expect_beat(2, mk(2, 1, 1'b0));
    expect_beat(2, mk(2, 2, 1'b1));
    expect_beat(3, mk(3, 0, 1'b1));
    wait_drain(cyc);
    chk("gap_cycles", 64'(cyc), 64'd9);

    // Backpressure: held beat stays stable with no source readied
    out_ready = 1'b0;
    load(0, 42'h2AB_CDEF_0123);
    load(0, mk(0, 7, 1'b1));
    expect_beat(0, 42'h2AB_CDEF_0123);
    expect_beat(0, mk(0, 7, 1'b1));
    repeat (2) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'h2AB_CDEF_0123);
      chk("stall_src", 64'(out_src), 64'd0);
      chk("stall_src_ready", 64'(src_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_data", 64'(out_data), 64'h2AB_CDEF_0123);
    @(negedge clk);
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_data", 64'(out_data), 64'(mk(0, 7, 1'b1)));
    wait_drain(cyc);

    // Reset during beat 2 of src1's burst; src0 must win after release
    for (int n = 0; n < 4; n++) load(1, mk(1, n, n == 3));
    load(0, mk(0, 5, 1'b1));
    expect_beat(1, mk(1, 0, 1'b0));
    expect_beat(1, mk(1, 1, 1'b0));
    expect_beat(0, mk(0, 5, 1'b1));
    expect_beat(1, mk(1, 2, 1'b0));
    expect_beat(1, mk(1, 3, 1'b1));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_out_src", 64'(out_src), 64'd0);
    chk("midrst_src_ready", 64'(src_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain(cyc);
    chk("post_rst_cycles", 64'(cyc), 64'd4);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/r_channel_arbiter.md
# r_channel_arbiter

Shares one AXI read-data (R) return path among several slave-side R sources, such as the per-slave clock-domain-crossing FIFOs, and delivers one 42-bit beat stream to a master port. It arbitrates round-robin at burst granularity: once a source wins, it keeps the path until its last beat is accepted, so bursts never interleave. The block has one registered output stage with full-throughput valid/ready handshakes on both sides. It sits in the interconnect, between the R FIFOs' read side and the master's R channel.

## Interface
- NUM_SRC, default 4: number of R sources; valid range 2–8.
- DW, default 42: beat payload width. Bit 0 of every payload is the RLAST flag.
- clk  in  1  single clock. The block runs entirely in this domain; all sources are already synchronized to it.
- rst_n  in  1  reset, synchronous and active-low.
- src_valid  in  NUM_SRC  per-source beat valid.
- src_data  in  NUM_SRC*DW  per-source payload; source i occupies bits [i*DW +: DW].
- src_ready  out  NUM_SRC  per-source ready. At most one bit is high in any cycle.
- out_valid  out  1  output beat valid.
- out_data  out  DW  output beat payload.
- out_src  out  max(1,$clog2(NUM_SRC))  index of the source that produced out_data.
- out_ready  in  1  downstream ready.

## Operation
- Load enable: `load_en = !out_valid || out_ready`.
- Grant selection:
  - State IDLE: the grant g is the first i with src_valid[i]=1, scanning rr_ptr, rr_ptr+1, … with modulo-NUM_SRC wrap.
  - State LOCK: g = lock_src. src_valid of all other sources is ignored.
- Ready: src_ready[g] = load_en when a grant exists. All other src_ready bits are 0.
- Accept: a beat is accepted when `src_valid[g] && src_ready[g]`. On accept:
  - out_data <= src_data[g]
  - out_src <= g
  - out_valid <= 1
- No accept while out_ready=1: out_valid <= 0 and out_data holds its value.
- Output stall (out_valid=1, out_ready=0): out_data and out_src are held stable, and no source is readied.
- State transitions:
  - IDLE → LOCK when an accepted beat has data[0]=0. lock_src <= g.
  - LOCK → IDLE when an accepted beat from lock_src has data[0]=1.
  - IDLE → IDLE on a single-beat accept (data[0]=1).
- Round-robin update: rr_ptr <= (g+1) mod NUM_SRC, on every accept that ends a burst (data[0]=1) only. rr_ptr does not change in the middle of a burst.
- LOCK with src_valid[lock_src]=0: the output bubbles and no other source is granted, however long the gap lasts.
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_src=0, state=IDLE, rr_ptr=0.
  - src_ready forced to all-0 combinationally while rst_n=0.
  - Reset in the middle of a burst drops the lock and discards any held beat.

## Timing
- Latency: a source beat accepted at edge k appears on out_valid/out_data from edge k to edge k+1, i.e. one register stage.
- Throughput: one beat per cycle while out_ready=1 and the granted source is valid.
- After a last beat is accepted at edge k, a different source can be accepted at edge k+1, so there are no dead cycles between bursts.
- src_ready depends combinationally on out_valid, out_ready, src_valid (in IDLE), state and rr_ptr. It never depends on src_data.
- Simultaneous events in IDLE: when several sources are valid, only the round-robin winner is readied; losers keep their data pending.

## Test plan
- Single-beat round-robin:
  - Stimulus: NUM_SRC=4, all sources continuously valid with 1-beat bursts (bit0=1), out_ready=1.
  - Required: out_src sequence 0,1,2,3,0…; one beat per cycle; out_valid high from the first edge after reset release.
- Burst lock:
  - Stimulus: src0 sends 4 beats (last on beat 4) while src1 and src2 stay valid.
  - Required: out_src=0 for 4 consecutive beats, then 1, then 2; src_ready[1] stays 0 during src0's burst.
- Mid-burst gap:
  - Stimulus: src2 locked after beat 1; src_valid[2] drops for 3 cycles while src3 is valid.
  - Required: out_valid=0 for those cycles; src3 is not granted; src2 resumes, and src3 is granted only after src2's last beat.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with a beat held (out_data=42'h2AB_CDEF_0123).
  - Required: out_data and out_src stable, all src_ready=0; the beat is accepted when out_ready rises, and the next beat follows on the next edge.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 during beat 2 of src1's 4-beat burst.
  - Required: next edge gives out_valid=0, out_data=0, state IDLE, rr_ptr=0; after release, src0 wins if valid.
